// File: rtl/fractal_renderer.sv
// Escape-time fractal renderer (Mandelbrot / Julia) driving a VGA plot interface.
// Scans a SCREEN_W x SCREEN_H viewport row-major, iterates z = z^2 + c in signed
// Q(INT_BITS).(FRAC_BITS) fixed point and plots one colour per pixel.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    level request, accepted in IDLE or DONE
//   mode                     0 = Mandelbrot, 1 = Julia
//   x0, y0, step             viewport origin and per-pixel increment (signed)
//   cr, ci                   Julia constant (signed)
//   max_iter                 iteration cap
//   plot_ready               adapter accepts the current plot
//   busy, done               frame status
//   vga_x, vga_y, vga_colour, vga_plot   plot interface
module fractal_renderer #(
    parameter int unsigned SCREEN_W  = 320,
    parameter int unsigned SCREEN_H  = 240,
    parameter int unsigned XW        = 9,
    parameter int unsigned YW        = 8,
    parameter int unsigned INT_BITS  = 10,
    parameter int unsigned FRAC_BITS = 22,
    parameter int unsigned ITW       = 8,
    parameter int unsigned COLOUR_W  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode,
    input  logic [INT_BITS+FRAC_BITS-1:0] x0,
    input  logic [INT_BITS+FRAC_BITS-1:0] y0,
    input  logic [INT_BITS+FRAC_BITS-1:0] step,
    input  logic [INT_BITS+FRAC_BITS-1:0] cr,
    input  logic [INT_BITS+FRAC_BITS-1:0] ci,
    input  logic [ITW-1:0]                max_iter,
    input  logic                          plot_ready,
    output logic                          busy,
    output logic                          done,
    output logic [XW-1:0]                 vga_x,
    output logic [YW-1:0]                 vga_y,
    output logic [COLOUR_W-1:0]           vga_colour,
    output logic                          vga_plot
);
    localparam int unsigned DW = INT_BITS + FRAC_BITS;
    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);
    localparam logic signed [DW+1:0] FOUR = $signed((DW+2)'(1) << (FRAC_BITS + 2));

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_PLOT, S_NEXT, S_DONE} state_t;

    state_t                 state_q, state_n;
    logic                   mode_q, mode_n;
    logic signed [DW-1:0]   x0_q, x0_n, step_q, step_n, cr_q, cr_n, ci_q, ci_n;
    logic [ITW-1:0]         max_iter_q, max_iter_n, iter_q, iter_n;
    logic [XW-1:0]          x_q, x_n;
    logic [YW-1:0]          y_q, y_n;
    logic signed [DW-1:0]   cre_q, cre_n, cim_q, cim_n;
    logic signed [DW-1:0]   zr_q, zr_n, zi_q, zi_n, cr_eff_q, cr_eff_n, ci_eff_q, ci_eff_n;
    logic                   busy_q, busy_n, done_q, done_n, plot_q, plot_n;
    logic [COLOUR_W-1:0]    colour_q, colour_n;

    // Fixed-point squares and cross product of the current z
    logic signed [2*DW-1:0] p_rr, p_ii, p_ri;
    logic signed [DW-1:0]   sq_rr, sq_ii, sq_ri, zr_step, zi_step;
    logic signed [DW+1:0]   mag;
    logic [COLOUR_W-1:0]    iter_low, esc_colour;
    logic                   escaped;

    assign p_rr    = (2*DW)'(zr_q) * (2*DW)'(zr_q);
    assign p_ii    = (2*DW)'(zi_q) * (2*DW)'(zi_q);
    assign p_ri    = (2*DW)'(zr_q) * (2*DW)'(zi_q);
    assign sq_rr   = DW'(p_rr >>> FRAC_BITS);
    assign sq_ii   = DW'(p_ii >>> FRAC_BITS);
    assign sq_ri   = DW'(p_ri >>> FRAC_BITS);
    // Magnitude widened by two bits so the sum of two squares cannot wrap
    assign mag     = (DW+2)'(sq_rr) + (DW+2)'(sq_ii);
    assign escaped = mag > FOUR;
    assign zr_step = sq_rr - sq_ii + cr_eff_q;
    assign zi_step = (sq_ri <<< 1) + ci_eff_q;
    // Escape colour 0 is reserved for "inside", so a zero low slice maps to 1
    assign iter_low   = iter_q[COLOUR_W-1:0];
    assign esc_colour = (iter_low == '0) ? COLOUR_W'(1) : iter_low;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            x0_q       <= '0;
            step_q     <= '0;
            cr_q       <= '0;
            ci_q       <= '0;
            max_iter_q <= '0;
            iter_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cre_q      <= '0;
            cim_q      <= '0;
            zr_q       <= '0;
            zi_q       <= '0;
            cr_eff_q   <= '0;
            ci_eff_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            plot_q     <= 1'b0;
            colour_q   <= '0;
        end else begin
            state_q    <= state_n;
            mode_q     <= mode_n;
            x0_q       <= x0_n;
            step_q     <= step_n;
            cr_q       <= cr_n;
            ci_q       <= ci_n;
            max_iter_q <= max_iter_n;
            iter_q     <= iter_n;
            x_q        <= x_n;
            y_q        <= y_n;
            cre_q      <= cre_n;
            cim_q      <= cim_n;
            zr_q       <= zr_n;
            zi_q       <= zi_n;
            cr_eff_q   <= cr_eff_n;
            ci_eff_q   <= ci_eff_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            plot_q     <= plot_n;
            colour_q   <= colour_n;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_n    = state_q;
        mode_n     = mode_q;
        x0_n       = x0_q;
        step_n     = step_q;
        cr_n       = cr_q;
        ci_n       = ci_q;
        max_iter_n = max_iter_q;
        iter_n     = iter_q;
        x_n        = x_q;
        y_n        = y_q;
        cre_n      = cre_q;
        cim_n      = cim_q;
        zr_n       = zr_q;
        zi_n       = zi_q;
        cr_eff_n   = cr_eff_q;
        ci_eff_n   = ci_eff_q;
        busy_n     = busy_q;
        done_n     = done_q;
        plot_n     = plot_q;
        colour_n   = colour_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_n     = mode;
                    x0_n       = $signed(x0);
                    step_n     = $signed(step);
                    cr_n       = $signed(cr);
                    ci_n       = $signed(ci);
                    max_iter_n = max_iter;
                    x_n        = '0;
                    y_n        = '0;
                    cre_n      = $signed(x0);
                    cim_n      = $signed(y0);
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    state_n    = S_INIT;
                end
            end
            S_INIT: begin
                if (mode_q) begin
                    zr_n     = cre_q;
                    zi_n     = cim_q;
                    cr_eff_n = cr_q;
                    ci_eff_n = ci_q;
                end else begin
                    zr_n     = '0;
                    zi_n     = '0;
                    cr_eff_n = cre_q;
                    ci_eff_n = cim_q;
                end
                iter_n  = '0;
                state_n = S_ITER;
            end
            S_ITER: begin
                if (escaped) begin
                    colour_n = esc_colour;
                    plot_n   = 1'b1;
                    state_n  = S_PLOT;
                end else if (iter_q == max_iter_q) begin
                    colour_n = '0;
                    plot_n   = 1'b1;
                    state_n  = S_PLOT;
                end else begin
                    zr_n   = zr_step;
                    zi_n   = zi_step;
                    iter_n = iter_q + ITW'(1);
                end
            end
            S_PLOT: begin
                if (plot_ready) begin
                    plot_n  = 1'b0;
                    state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                if (x_q < X_LAST) begin
                    x_n     = x_q + XW'(1);
                    cre_n   = cre_q + step_q;
                    state_n = S_INIT;
                end else if (y_q < Y_LAST) begin
                    x_n     = '0;
                    y_n     = y_q + YW'(1);
                    cre_n   = x0_q;
                    cim_n   = cim_q - step_q;
                    state_n = S_INIT;
                end else begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;
    assign vga_plot   = plot_q;
endmodule

// File: tb/tb_fractal_renderer.sv
// Self-checking bench for fractal_renderer on a 4x2 viewport.
`timescale 1ns/1ps
module tb_fractal_renderer;
    localparam int unsigned SW  = 4;
    localparam int unsigned SH  = 2;
    localparam int unsigned XW  = 9;
    localparam int unsigned YW  = 8;
    localparam int unsigned FB  = 22;
    localparam int unsigned DW  = 32;
    localparam int unsigned ITW = 8;
    localparam int unsigned CW  = 3;
    localparam int ONE = 1 << FB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic plot_ready = 1'b1;
    logic [DW-1:0] x0 = '0, y0 = '0, step = '0, cr = '0, ci = '0;
    logic [ITW-1:0] max_iter = '0;
    logic busy, done, vga_plot;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;

    fractal_renderer #(
        .SCREEN_W(SW), .SCREEN_H(SH), .XW(XW), .YW(YW),
        .INT_BITS(10), .FRAC_BITS(FB), .ITW(ITW), .COLOUR_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x0(x0), .y0(y0), .step(step), .cr(cr), .ci(ci),
        .max_iter(max_iter), .plot_ready(plot_ready),
        .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- plot monitor and plot_ready driver ----------------
    typedef struct { int x; int y; int colour; int cyc; int len; } xfer_t;
    xfer_t xq[$];
    int cyc = 0, done_rises = 0, plot_cycles = 0, run_len = 0;
    int ready_mode = 0, hold_cnt = 0;
    bit xf, prev_plot = 0, prev_xfer = 0, prev_done = 0;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [CW-1:0] pc;

    always @(negedge clk) begin
        cyc++;
        // ready value for the coming edge: 0 always ready, 1 random, 2 stall first plot 5 cycles
        if (ready_mode == 2 && vga_plot && hold_cnt < 5) begin
            plot_ready = 1'b0;
            hold_cnt++;
        end else if (ready_mode == 1) begin
            plot_ready = ($urandom_range(0, 2) != 0);
        end else begin
            plot_ready = 1'b1;
        end
        xf = vga_plot && plot_ready;
        if (prev_xfer) check("plot_drop", longint'(vga_plot), 0);
        if (vga_plot) begin
            plot_cycles++;
            run_len++;
            if (prev_plot && !prev_xfer) begin
                check("hold_x", longint'(vga_x), longint'(px));
                check("hold_y", longint'(vga_y), longint'(py));
                check("hold_colour", longint'(vga_colour), longint'(pc));
            end
        end else begin
            run_len = 0;
        end
        if (xf) begin
            xq.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour), cyc, run_len});
            run_len = 0;
        end
        if (done && !prev_done) done_rises++;
        prev_plot = vga_plot;
        prev_xfer = xf;
        prev_done = done;
        px = vga_x;
        py = vga_y;
        pc = vga_colour;
    end

    // ---------------- reference model ----------------
    function automatic int fx_mul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> FB);
    endfunction

    // Escape-time iteration for one point; k = iterations performed
    function automatic void ref_pixel(input bit m, input int pr, input int pi,
                                      input int jr, input int ji, input int mi,
                                      output int colour, output int k);
        int zr, zi, c_r, c_i, t;
        longint mag;
        if (m) begin zr = pr; zi = pi; c_r = jr; c_i = ji; end
        else   begin zr = 0;  zi = 0;  c_r = pr; c_i = pi; end
        colour = 0;
        k = mi;
        for (int it = 0; it <= mi; it++) begin
            mag = longint'(fx_mul(zr, zr)) + longint'(fx_mul(zi, zi));
            if (mag > (longint'(4) <<< FB)) begin
                k = it;
                colour = (it % (1 << CW) == 0) ? 1 : it % (1 << CW);
                return;
            end
            if (it == mi) begin
                k = it;
                colour = 0;
                return;
            end
            t  = fx_mul(zr, zr) - fx_mul(zi, zi) + c_r;
            zi = 2 * fx_mul(zr, zi) + c_i;
            zr = t;
        end
    endfunction

    // Run one frame; exp_col < 0 means use the model, otherwise a fixed colour/k for every pixel
    task automatic run_frame(input bit m, input int fx0, input int fy0, input int fstep,
                             input int fcr, input int fci, input int fmi, input int rmode,
                             input bit disturb, input bit timing, input int exp_col, input int exp_k);
        int col, k, d0, n, ex, ey;
        xq.delete();
        hold_cnt = 0;
        ready_mode = rmode;
        d0 = done_rises;
        @(negedge clk);
        mode = m; x0 = fx0; y0 = fy0; step = fstep; cr = fcr; ci = fci;
        max_iter = ITW'(fmi);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", longint'(busy), 1);
        check("done_after_start", longint'(done), 0);
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
            if (disturb && n == 10) begin
                check("busy_when_poked", longint'(busy), 1);
                x0 = fx0 + ONE;
                y0 = fy0 - ONE;
                mode = ~m;
                step = fstep + 12345;
                max_iter = ITW'(fmi + 7);
                start = 1'b1;
            end
            if (disturb && n == 12) start = 1'b0;
        end
        check("frame_done", longint'(done), 1);
        @(negedge clk);
        check("busy_at_done", longint'(busy), 0);
        check("done_once", longint'(done_rises - d0), 1);
        check("plot_count", longint'(xq.size()), longint'(SW * SH));
        for (int i = 0; i < xq.size() && i < int'(SW * SH); i++) begin
            ex = i % int'(SW);
            ey = i / int'(SW);
            ref_pixel(m, fx0 + ex * fstep, fy0 - ey * fstep, fcr, fci, fmi, col, k);
            if (exp_col >= 0) begin
                col = exp_col;
                k = exp_k;
            end
            check("px_x", longint'(xq[i].x), longint'(ex));
            check("px_y", longint'(xq[i].y), longint'(ey));
            check("px_colour", longint'(xq[i].colour), longint'(col));
            if (timing && i > 0)
                check("px_cycles", longint'(xq[i].cyc - xq[i-1].cyc), longint'(k + 4));
            if (rmode == 2)
                check("plot_len", longint'(xq[i].len), (i == 0) ? 6 : 1);
        end
    endtask

    typedef struct { bit m; int x0; int y0; int step; int cr; int ci; int mi; int col; int k; } vec_t;
    vec_t tbl[10];

    initial begin
        int n, pcnt;
        int rx0, ry0, rstep, rcr, rci, rmi;
        tbl[0] = '{1'b0, 0,        0, 0, 0, 0, 0,  0, 0};   // scan order, 4 cycles per pixel
        tbl[1] = '{1'b0, 0,        0, 0, 0, 0, 16, 0, 16};  // origin stays inside
        tbl[2] = '{1'b0, 3 * ONE,  0, 0, 0, 0, 16, 1, 1};   // c = 3 escapes at iter 1
        tbl[3] = '{1'b1, ONE,      0, 0, 0, 0, 20, 0, 20};  // Julia z = 1 fixed point
        tbl[4] = '{1'b1, 3*ONE/2,  0, 0, 0, 0, 20, 1, 1};   // Julia z = 1.5 escapes at iter 1
        tbl[5] = '{1'b0, -2 * ONE, 0, 0, 0, 0, 10, 0, 10};  // |z|^2 == 4 exactly is not an escape
        tbl[6] = '{1'b0, ONE,      0, 0, 0, 0, 16, 3, 3};   // c = 1: 0,1,2,5
        tbl[7] = '{1'b0, ONE,      0, 0, 0, 0, 3,  3, 3};   // escape wins when iter == max_iter
        tbl[8] = '{1'b0, ONE,      0, 0, 0, 0, 2,  0, 2};   // capped one short of escape
        tbl[9] = '{1'b0, ONE / 2,  0, 0, 0, 0, 16, 5, 5};   // c = 0.5 escapes at iter 5

        // power-up reset
        repeat (3) @(negedge clk);
        check("rst_plot", longint'(vga_plot), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_x", longint'(vga_x), 0);
        check("rst_colour", longint'(vga_colour), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_frame(tbl[i].m, tbl[i].x0, tbl[i].y0, tbl[i].step, tbl[i].cr, tbl[i].ci,
                      tbl[i].mi, 0, 1'b0, 1'b1, tbl[i].col, tbl[i].k);

        // back-pressure: first plot stalled 5 cycles
        run_frame(1'b0, ONE, 0, 0, 0, 0, 16, 2, 1'b0, 1'b0, 3, 3);

        // randomized viewports against the model, random plot_ready
        for (int r = 0; r < 8; r++) begin
            rx0   = int'($urandom_range(0, 3 * ONE)) - 2 * ONE;
            ry0   = int'($urandom_range(0, 3 * ONE)) - 3 * ONE / 2;
            rstep = int'($urandom_range(0, ONE / 4));
            rcr   = int'($urandom_range(0, 2 * ONE)) - ONE;
            rci   = int'($urandom_range(0, 2 * ONE)) - ONE;
            rmi   = int'($urandom_range(0, 40));
            run_frame(r[0], rx0, ry0, rstep, rcr, rci, rmi, (r < 4) ? 0 : 1, 1'b0, r < 4, -1, 0);
        end

        // config changes and start pokes mid-frame must not disturb the frame
        run_frame(1'b0, -ONE, ONE / 2, ONE / 8, 0, 0, 12, 1, 1'b1, 1'b0, -1, 0);
        run_frame(1'b1, -ONE / 2, ONE / 4, ONE / 16, -ONE / 2, ONE / 3, 15, 0, 1'b1, 1'b1, -1, 0);

        // reset asserted while a plot is stalled
        ready_mode = 2;
        hold_cnt = 0;
        @(negedge clk);
        mode = 1'b0; x0 = 0; y0 = 0; step = 0; max_iter = ITW'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!vga_plot && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("plot_before_reset", longint'(vga_plot), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_plot", longint'(vga_plot), 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_done", longint'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        pcnt = plot_cycles;
        repeat (30) @(negedge clk);
        check("no_plot_after_reset", longint'(plot_cycles - pcnt), 0);
        check("idle_busy", longint'(busy), 0);
        check("idle_done", longint'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fractal_renderer.md
Name: fractal_renderer

Overview:
Parametrised escape-time fractal renderer, successor to the fixed 320x240 Mandelbrot engine. It scans a runtime-configurable complex-plane viewport pixel by pixel in either Mandelbrot or Julia mode, iterates z = z² + c in signed fixed point, and emits one colour per pixel on the VGA plot interface. The plot interface supports back-pressure. The block sits between the top-level start/control logic and the VGA adapter.

Parameters:
SCREEN_W, 320, pixels per row
SCREEN_H, 240, rows per frame
XW, 9, vga_x width (must satisfy 2^XW >= SCREEN_W)
YW, 8, vga_y width (must satisfy 2^YW >= SCREEN_H)
INT_BITS, 10, integer bits of the signed fixed-point format
FRAC_BITS, 22, fraction bits; DW = INT_BITS + FRAC_BITS
ITW, 8, iteration-counter width
COLOUR_W, 3, vga_colour width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  level request; begins a frame when sampled high in IDLE
mode  in  1  0 = Mandelbrot, 1 = Julia
x0  in  DW  signed real part of pixel (0,0)
y0  in  DW  signed imaginary part of pixel (0,0)
step  in  DW  signed per-pixel increment; real part +step per column, imaginary part −step per row
cr, ci  in  DW each  signed Julia constant (ignored when mode=0)
max_iter  in  ITW  iteration cap
plot_ready  in  1  VGA adapter accepts the current plot
busy  out  1  frame in progress
done  out  1  frame complete
vga_x  out  XW  pixel column
vga_y  out  YW  pixel row
vga_colour  out  COLOUR_W  pixel colour
vga_plot  out  1  plot valid

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0. Applies immediately mid-frame; no further plots are issued.
- Configuration: mode, x0, y0, step, cr, ci and max_iter are latched on the start-accept cycle. Changes during a frame are ignored.
- IDLE: start=1 → latch config, x=y=0, cre=x0, cim=y0, busy=1, done=0 → INIT.
- INIT (1 cycle):
  - Mandelbrot: z=0, c=(cre,cim).
  - Julia: z=(cre,cim), c=(cr,ci).
  - iter=0 → ITER.
- ITER (1 cycle per iteration), using the current z:
  - mag = zr²+zi², computed in DW+2 bits (no overflow).
  - If mag > 4.0: escaped → PLOT.
  - Else if iter == max_iter: inside → PLOT.
  - Else z ← (zr²−zi²+cr_eff, 2·zr·zi+ci_eff), iter+1.
- Arithmetic:
  - Each product is the full 2·DW signed product, arithmetic-shifted right by FRAC_BITS and truncated to DW.
  - New z components wrap on overflow. No saturation; the escape test normally fires first.
- Colour:
  - Inside: 0.
  - Escaped: iter[COLOUR_W-1:0]; if that is 0, output 1.
- PLOT: vga_plot=1 with vga_x/vga_y/vga_colour stable. Hold until a cycle with plot_ready=1, which completes the transfer → NEXT. vga_plot drops the following cycle.
- NEXT (1 cycle):
  - If x < SCREEN_W−1: x+1, cre+=step.
  - Else if y < SCREEN_H−1: x=0, y+1, cre=x0_latched, cim−=step.
  - Else → DONE.
  - Otherwise → INIT.
- DONE: busy=0, done=1. done stays high until the next start is accepted. start held high in DONE begins a new frame (done clears the same cycle start is accepted).
- start while busy: ignored.
- Pixel latency: 1 INIT + (k+1) ITER + ≥1 PLOT + 1 NEXT cycles, where k = iterations performed.
- Scan order: row-major, (0,0) first, (SCREEN_W−1, SCREEN_H−1) last. Exactly SCREEN_W·SCREEN_H plots per frame.

Test Plan:
- Reset values: assert rst mid-frame → same cycle vga_plot=0, busy=0, done=0; after release, no plots until start.
- Order and count: SCREEN_W=4, SCREEN_H=2, max_iter=0, plot_ready=1 → 8 plots, colour 0, order (0,0),(1,0)…(3,1); then done=1; each pixel takes 4 cycles.
- Mandelbrot inside and outside:
  - x0=y0=0, step=0, max_iter=16 → every plot colour 0, 17 ITER cycles per pixel.
  - x0=3.0 (0x00C00000) → colour 1.
- Julia: mode=1, cr=ci=0, step=0:
  - x0=1.0 (0x00400000), max_iter=20 → colour 0.
  - x0=1.5 (0x00600000) → escapes at iter=1, colour 1.
- Back-pressure: plot_ready low for 5 cycles during a PLOT → vga_plot, vga_x/vga_y/vga_colour stable for all 6 cycles; single transfer counted.
- Config isolation: change x0 and mode mid-frame, pulse start while busy → frame output identical to an undisturbed golden-model run; done asserted exactly once.
